packet_scheduler: RTL and testbench
===================================

PACKET_SCHEDULER -- requirements
Module: packet_scheduler

Interface
REQ-001 SHALL have parameter INFO_PERIOD, default 1: ACR+AIF header sequence sent every INFO_PERIOD frames; legal range 1..255.
REQ-002 SHALL have parameter AUDIO_COUNT_WIDTH, default 8: width of audio_remaining.
REQ-003 SHALL have port clk_pixel, input, 1: single clock, the pixel clock.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port frame_start, input, 1: one-cycle pulse at cx==0 && cy==0.
REQ-006 SHALL have port packet_enable, input, 1: one-cycle pulse requesting the next data-island packet type.
REQ-007 SHALL have port audio_remaining, input, AUDIO_COUNT_WIDTH: sample-packet count ready in the audio buffer.
REQ-008 SHALL have port packet_type, output, 8: registered packet type fed to the HDMI encoder.
REQ-009 SHALL have port audio_pop, output, 1: registered one-cycle pulse, high in the same cycle packet_type first shows 8'h02 for that slot.
REQ-010 SHALL have port underrun_count, output, 16: saturating count of NULL packets emitted in STREAM.

Function
REQ-011 SHALL implement states WAIT_FRAME, SEND_ACR, SEND_AIF, [SEND_SPD], STREAM.
REQ-012 In WAIT_FRAME, packet_enable SHALL load packet_type 8'h00 and keep the state; frame_start is the only exit.
REQ-013 On frame_start, frame_cnt SHALL advance (wrap INFO_PERIOD-1 -> 0); next state SEND_ACR when new frame_cnt==0, else STREAM.
REQ-014 On packet_enable in SEND_ACR: packet_type <= 8'h01, next SEND_AIF.
REQ-015 On packet_enable in SEND_AIF: packet_type <= 8'h84, next SEND_SPD if compiled in, else STREAM.
REQ-016 On packet_enable in STREAM: audio_remaining>0 -> packet_type <= 8'h02 and audio_pop <= 1; else packet_type <= 8'h00 and underrun_count increments, saturating at 16'hFFFF.
REQ-017 Latency SHALL be one cycle: packet_type/audio_pop update on the clock edge following the packet_enable cycle; packet_type holds until the next packet_enable.
REQ-018 audio_pop SHALL deassert the cycle after it asserts; at most one pop per packet_enable.
REQ-019 frame_start and packet_enable in the same cycle: frame_start SHALL take effect first; that packet_enable SHALL be served from the state selected by REQ-013 (SEND_ACR -> emit 8'h01, state SEND_AIF).
REQ-020 frame_start arriving mid-sequence (e.g., in SEND_AIF) SHALL abort the remainder and apply REQ-013.
REQ-021 packet_enable with no frame_start outside WAIT_FRAME SHALL never return to WAIT_FRAME.
REQ-022 audio_remaining SHALL be sampled only in the packet_enable cycle; other-cycle changes SHALL have no effect.

Reset
REQ-023 rst_n low SHALL asynchronously force state WAIT_FRAME, packet_type 8'h00, audio_pop 0, underrun_count 0, frame_cnt INFO_PERIOD-1 (so first frame_start selects SEND_ACR).
REQ-024 Deassertion SHALL be sampled synchronously; first packet_enable after release SHALL be handled per REQ-012.
REQ-025 Reset asserted mid-sequence SHALL discard in-flight state; no audio_pop during or in the first cycle after reset.

Configuration
REQ-026 Macro PACKET_SCHEDULER_SPD_EN defined: state SEND_SPD SHALL exist; packet_enable there SHALL load 8'h83 then go STREAM.
REQ-027 Macro undefined: SEND_SPD and 8'h83 SHALL be absent; SEND_AIF goes directly to STREAM.

Verification
REQ-028 Reset, frame_start, then 4 packet_enable with audio_remaining=3 -> packet_type 01, 84, 02, 02; audio_pop exactly twice (SPD undefined).
REQ-029 STREAM with audio_remaining=0 for 5 packet_enable -> packet_type 00 each, underrun_count 5, audio_pop never high.
REQ-030 INFO_PERIOD=3, frames 1..4 each with 2 packet_enable, audio_remaining=1 -> ACR/AIF only in frames 1 and 4; frames 2,3 give 02,02.
REQ-031 frame_start and packet_enable same cycle while in STREAM (frame_cnt wraps to 0) -> next cycle packet_type 01; following enable -> 84.
REQ-032 rst_n pulsed low asynchronously between clock edges while in SEND_AIF -> outputs zero immediately; enable before next frame_start -> 00.
REQ-033 PACKET_SCHEDULER_SPD_EN defined -> sequence 01, 84, 83, then 02/00 per audio_remaining.

Source files
------------

// File: rtl/packet_scheduler.sv
// HDMI data-island packet type scheduler: ACR/AIF(/SPD) per info period,
// then audio samples or NULL per packet slot. Optional: PACKET_SCHEDULER_SPD_EN.
// Ports: clk_pixel, rst_n (async low), frame_start, packet_enable,
//        audio_remaining -> packet_type, audio_pop, underrun_count.
module packet_scheduler #(
  parameter int INFO_PERIOD       = 1,
  parameter int AUDIO_COUNT_WIDTH = 8
) (
  input  logic                         clk_pixel,
  input  logic                         rst_n,
  input  logic                         frame_start,
  input  logic                         packet_enable,
  input  logic [AUDIO_COUNT_WIDTH-1:0] audio_remaining,
  output logic [7:0]                   packet_type,
  output logic                         audio_pop,
  output logic [15:0]                  underrun_count
);

  localparam logic [7:0] LAST = 8'(INFO_PERIOD - 1);

  localparam logic [7:0] PT_NULL  = 8'h00;
  localparam logic [7:0] PT_ACR   = 8'h01;
  localparam logic [7:0] PT_AUDIO = 8'h02;
  localparam logic [7:0] PT_AIF   = 8'h84;
`ifdef PACKET_SCHEDULER_SPD_EN
  localparam logic [7:0] PT_SPD   = 8'h83;
`endif

  typedef enum logic [2:0] {
    WAIT_FRAME,
    SEND_ACR,
    SEND_AIF,
`ifdef PACKET_SCHEDULER_SPD_EN
    SEND_SPD,
`endif
    STREAM
  } state_t;

  state_t     state;
  state_t     cur;
  logic [7:0] frame_cnt;
  logic [7:0] frame_nxt;
  logic [7:0] cnt_eff;

  // frame_start is resolved before packet_enable in the same cycle,
  // so the slot is served from the state the new frame selects.
  always_comb begin
    frame_nxt = (frame_cnt == LAST) ? 8'h00 : frame_cnt + 8'h01;
    cnt_eff   = frame_cnt;
    cur       = state;
    if (frame_start) begin
      cnt_eff = frame_nxt;
      cur     = (frame_nxt == 8'h00) ? SEND_ACR : STREAM;
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state          <= WAIT_FRAME;
      frame_cnt      <= LAST;
      packet_type    <= PT_NULL;
      audio_pop      <= 1'b0;
      underrun_count <= 16'h0000;
    end else begin
      audio_pop <= 1'b0;
      frame_cnt <= cnt_eff;
      state     <= cur;
      if (packet_enable) begin
        unique case (cur)
          WAIT_FRAME: begin
            packet_type <= PT_NULL;
          end
          SEND_ACR: begin
            packet_type <= PT_ACR;
            state       <= SEND_AIF;
          end
          SEND_AIF: begin
            packet_type <= PT_AIF;
`ifdef PACKET_SCHEDULER_SPD_EN
            state       <= SEND_SPD;
`else
            state       <= STREAM;
`endif
          end
`ifdef PACKET_SCHEDULER_SPD_EN
          SEND_SPD: begin
            packet_type <= PT_SPD;
            state       <= STREAM;
          end
`endif
          STREAM: begin
            if (audio_remaining != '0) begin
              packet_type <= PT_AUDIO;
              audio_pop   <= 1'b1;
            end else begin
              packet_type <= PT_NULL;
              if (underrun_count != 16'hFFFF)
                underrun_count <= underrun_count + 16'h0001;
            end
          end
          default: begin
            packet_type <= PT_NULL;
            state       <= WAIT_FRAME;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_packet_scheduler.sv
// Directed bench for packet_scheduler: two instances (INFO_PERIOD 1 and 3)
// driven by the same stimulus, checked against hand-derived values.
module tb_packet_scheduler;

`ifdef PACKET_SCHEDULER_SPD_EN
  localparam bit SPD = 1'b1;
`else
  localparam bit SPD = 1'b0;
`endif

  logic        clk_pixel = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        packet_enable = 1'b0;
  logic [7:0]  audio_remaining = 8'd0;
  logic [7:0]  pt1, pt3;
  logic        pop1, pop3;
  logic [15:0] ur1, ur3;

  int checks = 0;
  int failures = 0;
  int pops = 0;

  packet_scheduler #(.INFO_PERIOD(1), .AUDIO_COUNT_WIDTH(8)) d1 (
    .clk_pixel(clk_pixel), .rst_n(rst_n), .frame_start(frame_start),
    .packet_enable(packet_enable), .audio_remaining(audio_remaining),
    .packet_type(pt1), .audio_pop(pop1), .underrun_count(ur1)
  );

  packet_scheduler #(.INFO_PERIOD(3), .AUDIO_COUNT_WIDTH(8)) d3 (
    .clk_pixel(clk_pixel), .rst_n(rst_n), .frame_start(frame_start),
    .packet_enable(packet_enable), .audio_remaining(audio_remaining),
    .packet_type(pt3), .audio_pop(pop3), .underrun_count(ur3)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic fs, input logic pe);
    frame_start   = fs;
    packet_enable = pe;
    @(posedge clk_pixel);
    #1;
    frame_start   = 1'b0;
    packet_enable = 1'b0;
    if (pop1) pops++;
  endtask

  initial begin
    #12;
    chk("rst_pt", pt1, 8'h00);
    chk("rst_pop", pop1, 0);
    chk("rst_ur", ur1, 0);
    @(posedge clk_pixel); #1;
    rst_n = 1'b1;
    @(posedge clk_pixel); #1;

    tick(0, 1);
    chk("wait_pe", pt1, 8'h00);
    chk("wait_ur", ur1, 0);

    pops = 0;
    audio_remaining = 8'd3;
    tick(1, 0);
    chk("f_idle", pt1, 8'h00);
    tick(0, 1); chk("seq0", pt1, 8'h01);
    tick(0, 1); chk("seq1", pt1, 8'h84);
    tick(0, 1); chk("seq2", pt1, SPD ? 8'h83 : 8'h02);
    chk("pop_seq2", pop1, SPD ? 0 : 1);
    tick(0, 1); chk("seq3", pt1, 8'h02);
    chk("pop_seq3", pop1, 1);
    tick(0, 0);
    chk("pop_drop", pop1, 0);
    chk("pop_cnt", pops, SPD ? 1 : 2);
    chk("d3_f1", pt3, 8'h02);

    pops = 0;
    audio_remaining = 8'd0;
    for (int i = 0; i < 5; i++) begin
      tick(0, 1);
      chk("ur_pt", pt1, 8'h00);
    end
    chk("ur_cnt", ur1, 5);
    chk("ur_pop", pops, 0);

    audio_remaining = 8'd1;
    tick(0, 0);
    audio_remaining = 8'd0;
    tick(0, 1);
    chk("samp_pt", pt1, 8'h00);
    chk("samp_ur", ur1, 6);

    audio_remaining = 8'd1;
    tick(1, 0); tick(0, 1);
    chk("f2_d1", pt1, 8'h01);
    chk("f2_a", pt3, 8'h02);
    tick(0, 1); chk("f2_b", pt3, 8'h02);
    tick(1, 0); tick(0, 1); chk("f3_a", pt3, 8'h02);
    tick(0, 1); chk("f3_b", pt3, 8'h02);
    tick(1, 0); tick(0, 1); chk("f4_a", pt3, 8'h01);
    tick(0, 1); chk("f4_b", pt3, 8'h84);

    tick(0, 1); chk("st_a", pt1, SPD ? 8'h83 : 8'h02);
    tick(0, 1); chk("st_b", pt1, 8'h02);
    tick(1, 1);
    chk("same_d1", pt1, 8'h01);
    chk("same_d3", pt3, 8'h02);
    tick(0, 1); chk("same_nx", pt1, 8'h84);

    tick(1, 0); tick(0, 1); chk("ab_a", pt1, 8'h01);
    tick(1, 0); tick(0, 1); chk("ab_b", pt1, 8'h01);

    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pt", pt1, 8'h00);
    chk("arst_ur", ur1, 0);
    chk("arst_pop", pop1, 0);
    chk("arst_ur3", ur3, 0);
    #4;
    rst_n = 1'b1;
    @(posedge clk_pixel); #1;
    chk("post_pop", pop1, 0);
    tick(0, 1);
    chk("post_pe", pt1, 8'h00);
    chk("post_pe_pop", pop1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
